// File: rtl/mem_arb_pkg.sv
// Shared definitions for the slow-memory arbiters: state encoding, requester IDs
// and default bus widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Requester IDs are one bit so that "the other requester" is a plain inversion.
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin / fixed-priority picker; purely combinational so wider
// arbiters can chain or tree it.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_gnt,
    input  logic fixed_prio,
    output logic winner
);

    always_comb begin
        winner = ID_I;
        if (req_i && req_d) begin
            // On a tie the side that did not win last time goes next.
            winner = fixed_prio ? ID_D : ~last_gnt;
        end else if (req_d) begin
            winner = ID_D;
        end
    end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Shares one slow-memory port between the I_cache and D_cache, one grant at a time.
// Optional performance counters are enabled with the MEM_ARB_PERF_CNT_EN macro.
module mem_arbiter_2to1
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_gnt_i,
    output logic [CNT_W-1:0]  cnt_gnt_d,
    output logic [CNT_W-1:0]  cnt_wait
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mem_arbiter_2to1: CNT_W must be at least 1");
    end

    arb_state_e state, state_next;
    logic       last_gnt, last_gnt_next;
    logic       req_i, req_d, winner;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    rr_pick2 u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_gnt   (last_gnt),
        .fixed_prio (FIXED_PRIO != 0),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state    <= IDLE;
            last_gnt <= ID_I;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        i_ready       = 1'b0;
        d_ready       = 1'b0;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = (winner == ID_D) ? GNT_D : GNT_I;
                end
            end
            GNT_I: begin
                // A write wins over a simultaneous read from the same requester.
                mem_read  = i_read & ~i_write;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
                if (mem_ready) begin
                    state_next    = IDLE;
                    last_gnt_next = ID_I;
                end else if (!req_i) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                mem_read  = d_read & ~d_write;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
                if (mem_ready) begin
                    state_next    = IDLE;
                    last_gnt_next = ID_D;
                end else if (!req_d) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data is broadcast; only the ready strobe tells a cache it is meant for it.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    logic waiting;
    assign waiting = (req_i && (state != GNT_I)) || (req_d && (state != GNT_D));

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            cnt_gnt_i <= '0;
            cnt_gnt_d <= '0;
            cnt_wait  <= '0;
        end else begin
            cnt_gnt_i <= sat_inc(cnt_gnt_i, (state == GNT_I) && mem_ready);
            cnt_gnt_d <= sat_inc(cnt_gnt_d, (state == GNT_D) && mem_ready);
            cnt_wait  <= sat_inc(cnt_wait, waiting);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Scoreboard bench for mem_arbiter_2to1: a transaction-level model predicts every
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_mem_arbiter_2to1;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int FP  = 0;
    localparam int CW  = 32;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, i_ready;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata, i_rdata;
    logic          d_read, d_write, d_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [CW-1:0] cnt_gnt_i, cnt_gnt_d, cnt_wait;
`endif

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(
        .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(FP), .CNT_W(CW)
    ) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_PERF_CNT_EN
        , .cnt_gnt_i(cnt_gnt_i), .cnt_gnt_d(cnt_gnt_d), .cnt_wait(cnt_wait)
`endif
    );

    typedef struct {
        logic [1:0]    ctl;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    rdy;
        logic [DW-1:0] rdata;
`ifdef MEM_ARB_PERF_CNT_EN
        logic [CW-1:0] ci, cd, cw;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    // Reference model: who owns the memory (0 none, 1 I, 2 D) and who was served last.
    int owner = 0;
    int last = 1;
    int gcnt = 0;
    int lat = LAT;
    bit lat_rand = 1'b0;
    int stray_pct = 0;
    bit done[2];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [CW-1:0] m_ci = '0, m_cd = '0, m_cw = '0;
`endif

    bit            pend[2];
    logic          rq_rd[2], rq_wr[2];
    logic [AW-1:0] rq_ad[2];
    logic [DW-1:0] rq_wd[2];

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

`ifdef MEM_ARB_PERF_CNT_EN
    function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction
`endif

    function automatic exp_t predict();
        exp_t e;
        e.ctl   = 2'b00;
        e.addr  = '0;
        e.wdata = '0;
        if (owner == 1) begin
            e.ctl   = {i_read & ~i_write, i_write};
            e.addr  = i_addr;
            e.wdata = i_wdata;
        end else if (owner == 2) begin
            e.ctl   = {d_read & ~d_write, d_write};
            e.addr  = d_addr;
            e.wdata = d_wdata;
        end
        e.rdy   = {owner == 1 && mem_ready, owner == 2 && mem_ready};
        e.rdata = mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
        e.ci = m_ci;
        e.cd = m_cd;
        e.cw = m_cw;
`endif
        return e;
    endfunction

    function automatic void model_edge();
        logic ri, rd;
        ri = i_read | i_write;
        rd = d_read | d_write;
        done[0] = 1'b0;
        done[1] = 1'b0;
        if (proc_reset) begin
            owner = 0;
            last  = 1;
            gcnt  = 0;
`ifdef MEM_ARB_PERF_CNT_EN
            m_ci = '0;
            m_cd = '0;
            m_cw = '0;
`endif
            return;
        end
`ifdef MEM_ARB_PERF_CNT_EN
        if ((ri && owner != 1) || (rd && owner != 2)) m_cw = sat(m_cw);
        if (owner == 1 && mem_ready) m_ci = sat(m_ci);
        if (owner == 2 && mem_ready) m_cd = sat(m_cd);
`endif
        if (owner == 0) begin
            if (ri && rd) owner = (FP != 0) ? 2 : 3 - last;
            else if (rd) owner = 2;
            else if (ri) owner = 1;
            gcnt = 0;
            if (lat_rand) lat = int'($urandom_range(1, 6));
        end else if (mem_ready) begin
            done[owner-1] = 1'b1;
            last  = owner;
            owner = 0;
        end else if ((owner == 1 && !ri) || (owner == 2 && !rd)) begin
            owner = 0;
        end else begin
            gcnt++;
        end
    endfunction

    // Drives requester ports and plays the slow memory from the model's view of the grant.
    function automatic void apply();
        i_read  = rq_rd[0];
        i_write = rq_wr[0];
        i_addr  = rq_ad[0];
        i_wdata = rq_wd[0];
        d_read  = rq_rd[1];
        d_write = rq_wr[1];
        d_addr  = rq_ad[1];
        d_wdata = rq_wd[1];
        mem_rdata = rand128();
        if ((owner == 1 && (i_read || i_write)) || (owner == 2 && (d_read || d_write)))
            mem_ready = (gcnt >= lat - 1);
        else if (owner != 0)
            mem_ready = 1'b0;
        else
            mem_ready = (int'($urandom_range(0, 99)) < stray_pct);
    endfunction

    task automatic step();
        if (chk_en) exp_q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (i_ready) grant_log.push_back(1);
        if (d_ready) grant_log.push_back(2);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_ctl", DW'({mem_read, mem_write}), DW'(e.ctl));
            check("mem_addr", DW'(mem_addr), DW'(e.addr));
            check("mem_wdata", mem_wdata, e.wdata);
            check("ready", DW'({i_ready, d_ready}), DW'(e.rdy));
            check("i_rdata", i_rdata, e.rdata);
            check("d_rdata", d_rdata, e.rdata);
`ifdef MEM_ARB_PERF_CNT_EN
            check("cnt_gnt_i", DW'(cnt_gnt_i), DW'(e.ci));
            check("cnt_gnt_d", DW'(cnt_gnt_d), DW'(e.cd));
            check("cnt_wait", DW'(cnt_wait), DW'(e.cw));
`endif
        end
    end

    initial begin
        int ncomp;
        int kind;
        int first;
        bit got;
        for (int x = 0; x < 2; x++) begin
            pend[x]  = 1'b0;
            rq_rd[x] = 1'b0;
            rq_wr[x] = 1'b0;
            rq_ad[x] = '0;
            rq_wd[x] = '0;
        end
        proc_reset = 1'b1;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // Reset with both reads held, then contended persistent reads.
        rq_rd[0] = 1'b1;
        rq_rd[1] = 1'b1;
        rq_ad[0] = 28'h0000100;
        rq_ad[1] = 28'h0000010;
        rq_wd[0] = rand128();
        rq_wd[1] = rand128();
        apply(); step();
        chk_en = 1'b1;
        apply(); step();
        proc_reset = 1'b0;
        grant_log.delete();
        ncomp = 0;
        for (int k = 0; k < 200 && ncomp < 5; k++) begin
            apply(); step();
            ncomp += int'(done[0]) + int'(done[1]);
        end
        rq_rd[0] = 1'b0;
        rq_rd[1] = 1'b0;
        apply(); step();
        apply(); step();
        check("contend_done", DW'(ncomp), DW'(5));
        check("contend_count", DW'(grant_log.size()), DW'(5));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("contend_order", DW'(grant_log[k]), DW'((FP != 0 || k % 2 == 0) ? 2 : 1));
`ifdef MEM_ARB_PERF_CNT_EN
        check("cnt_gnt_d_contend", DW'(cnt_gnt_d), DW'((FP != 0) ? 5 : 3));
        check("cnt_gnt_i_contend", DW'(cnt_gnt_i), DW'((FP != 0) ? 0 : 2));
        check("cnt_wait_contend", DW'(cnt_wait), DW'(5 * (LAT + 1)));
`endif

        // Single D read at 0x10.
        proc_reset = 1'b1;
        apply(); step();
        proc_reset = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
        check("cnt_clear", DW'({cnt_gnt_i, cnt_gnt_d, cnt_wait}), DW'(0));
`endif
        rq_rd[1] = 1'b1;
        rq_ad[1] = 28'h0000010;
        for (int k = 0; k < 30 && !done[1]; k++) begin
            apply(); step();
        end
        got = done[1];
        rq_rd[1] = 1'b0;
        apply(); step();
        apply(); step();
        check("d_read_done", DW'(got), DW'(1));

        // D read and write together: only the write may reach memory.
        rq_rd[1] = 1'b1;
        rq_wr[1] = 1'b1;
        rq_wd[1] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0BAD_F00D;
        for (int k = 0; k < 30 && !done[1]; k++) begin
            apply(); step();
        end
        got = done[1];
        rq_rd[1] = 1'b0;
        rq_wr[1] = 1'b0;
        apply(); step();
        check("conflict_done", DW'(got), DW'(1));

        // I abandons two cycles before memory would answer; stray readies follow.
        lat = 10;
        grant_log.delete();
        rq_rd[0] = 1'b1;
        rq_ad[0] = AW'($urandom());
        for (int k = 0; k < 20 && !(owner == 1 && gcnt >= 7); k++) begin
            apply(); step();
        end
        check("abandon_reach", DW'(owner == 1 && gcnt >= 7), DW'(1));
        rq_rd[0] = 1'b0;
        stray_pct = 100;
        repeat (4) begin
            apply(); step();
        end
        stray_pct = 0;
        check("stray_ready", DW'(grant_log.size()), DW'(0));
        lat = 3;
        rq_rd[0] = 1'b1;
        rq_rd[1] = 1'b1;
        for (int k = 0; k < 30 && !(done[0] || done[1]); k++) begin
            apply(); step();
        end
        rq_rd[0] = 1'b0;
        rq_rd[1] = 1'b0;
        apply(); step();
        apply(); step();
        first = (grant_log.size() > 0) ? grant_log[0] : 0;
        check("post_abandon_pick", DW'(first), DW'((FP != 0) ? 2 : 1));

        // Random traffic: mixed reads/writes, abandons, stray readies, mid-flight resets.
        lat_rand  = 1'b1;
        stray_pct = 20;
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (done[x] || (pend[x] && $urandom_range(0, 31) == 0)) pend[x] = 1'b0;
                if (!pend[x] && $urandom_range(0, 2) == 0) begin
                    kind     = int'($urandom_range(0, 9));
                    pend[x]  = 1'b1;
                    rq_rd[x] = (kind < 6 || kind == 9);
                    rq_wr[x] = (kind >= 6);
                    rq_ad[x] = AW'($urandom());
                    rq_wd[x] = rand128();
                end
                if (!pend[x]) begin
                    rq_rd[x] = 1'b0;
                    rq_wr[x] = 1'b0;
                end
            end
            proc_reset = ($urandom_range(0, 199) == 0);
            apply(); step();
        end
        proc_reset = 1'b0;
        stray_pct  = 0;
        for (int x = 0; x < 2; x++) begin
            pend[x]  = 1'b0;
            rq_rd[x] = 1'b0;
            rq_wr[x] = 1'b0;
        end
        repeat (3) begin
            apply(); step();
        end
        chk_en = 1'b0;
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("queue_drained", DW'(exp_q.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
